ascii_n_ints: RTL and testbench

//   Parametrised successor to the 4-channel ASCII integer stepper.

---
 rtl/ascii_pkg.sv | 31 +++
 rtl/ascii_digit.sv | 81 ++++++++
 rtl/ascii_n_ints.sv | 102 ++++++++++
 tb/tb_ascii_n_ints.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_pkg
//  Description : Shared constants and helpers for the ASCII odometer blocks.
//                Provides the default character-range codes and an unsigned
//                inclusive range test used on parallel-load data.
//  Revision    : 1.0  initial release
// ============================================================================
package ascii_pkg;

  // Default range endpoints and common digit codes.
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  // Common width for range comparisons; channel codes are zero-extended to
  // this width so one helper serves every CHAR_W up to 32 bits.
  localparam int unsigned ASCII_CMP_W = 32;

  // Unsigned inclusive test: lo <= code <= hi.
  function automatic logic in_range(
    input logic [ASCII_CMP_W-1:0] code,
    input logic [ASCII_CMP_W-1:0] lo,
    input logic [ASCII_CMP_W-1:0] hi
  );
    return (code >= lo) && (code <= hi);
  endfunction

endpackage : ascii_pkg
`default_nettype wire

// File: rtl/ascii_digit.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_digit
//  Description : One odometer channel. Holds a character code within
//                [FIRST_CHAR..LAST_CHAR], steps up or down by one when a
//                carry/borrow arrives, wraps at the range ends and reports the
//                wrap as carry_out. A parallel load replaces the code; codes
//                outside the range are replaced by FIRST_CHAR and flagged.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   1       rising-edge clock
//    rst        in   1       synchronous active-high reset (value <= FIRST_CHAR)
//    carry_in   in   1       step request for this channel (carry or borrow)
//    dir        in   1       0 = step up, 1 = step down
//    load       in   1       parallel load strobe (overrides carry_in)
//    load_val   in   CHAR_W  code to load
//    value      out  CHAR_W  registered channel code
//    carry_out  out  1       this channel wraps on the current step
//    bad_load   out  1       load is active and load_val is out of range
// ============================================================================
module ascii_digit
  import ascii_pkg::*;
#(
  parameter int unsigned         CHAR_W     = 8,
  parameter logic [CHAR_W-1:0]   FIRST_CHAR = CHAR_W'(ASCII_SPACE),
  parameter logic [CHAR_W-1:0]   LAST_CHAR  = CHAR_W'(ASCII_TILDE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              carry_in,
  input  logic              dir,
  input  logic              load,
  input  logic [CHAR_W-1:0] load_val,
  output logic [CHAR_W-1:0] value,
  output logic              carry_out,
  output logic              bad_load
);

  logic [CHAR_W-1:0] value_q;
  logic [CHAR_W-1:0] value_d;
  logic              at_limit;
  logic              load_ok;

  always_comb begin
    // The limit that causes a wrap depends on the counting direction.
    at_limit = dir ? (value_q == FIRST_CHAR) : (value_q == LAST_CHAR);
    load_ok  = in_range(ASCII_CMP_W'(load_val),
                        ASCII_CMP_W'(FIRST_CHAR),
                        ASCII_CMP_W'(LAST_CHAR));

    value_d = value_q;
    if (load) begin
      value_d = load_ok ? load_val : FIRST_CHAR;
    end else if (carry_in) begin
      if (at_limit) begin
        value_d = dir ? LAST_CHAR : FIRST_CHAR;
      end else if (dir) begin
        value_d = value_q - CHAR_W'(1);
      end else begin
        value_d = value_q + CHAR_W'(1);
      end
    end
  end

  // Combinational ripple: a wrap in this channel steps the next one in the
  // same cycle. A load never generates a carry.
  assign carry_out = carry_in & at_limit & ~load;
  assign bad_load  = load & ~load_ok;
  assign value     = value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= FIRST_CHAR;
    end else begin
      value_q <= value_d;
    end
  end

endmodule : ascii_digit
`default_nettype wire

// File: rtl/ascii_n_ints.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_n_ints
//  Description : NUM_CHARS-channel ASCII odometer. Channels count in a mixed
//                radix over [FIRST_CHAR..LAST_CHAR], channel 0 least
//                significant. Supports up/down stepping, parallel load with
//                range checking, and a full-odometer wrap flag that is either
//                a one-cycle pulse or sticky until cleared.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in   1                 rising-edge clock
//    rst         in   1                 synchronous active-high reset
//    next        in   1                 one step per cycle while high
//    dir         in   1                 0 = up, 1 = down
//    load        in   1                 parallel load (wins over next)
//    load_value  in   NUM_CHARS*CHAR_W  channel i at [i*CHAR_W +: CHAR_W]
//    ovf_clr     in   1                 clears sticky overflow
//    values      out  NUM_CHARS*CHAR_W  registered channel codes
//    overflow    out  1                 full-odometer wrap flag
//    range_err   out  1                 one-cycle pulse on out-of-range load
// ============================================================================
module ascii_n_ints
  import ascii_pkg::*;
#(
  parameter int unsigned         NUM_CHARS  = 4,
  parameter int unsigned         CHAR_W     = 8,
  parameter logic [CHAR_W-1:0]   FIRST_CHAR = CHAR_W'(ASCII_SPACE),
  parameter logic [CHAR_W-1:0]   LAST_CHAR  = CHAR_W'(ASCII_TILDE),
  parameter bit                  STICKY_OVF = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          next,
  input  logic                          dir,
  input  logic                          load,
  input  logic [NUM_CHARS*CHAR_W-1:0]   load_value,
  input  logic                          ovf_clr,
  output logic [NUM_CHARS*CHAR_W-1:0]   values,
  output logic                          overflow,
  output logic                          range_err
);

  // carry[i] is the step request entering channel i; carry[NUM_CHARS] is the
  // carry/borrow leaving the top channel, i.e. the full-odometer wrap.
  logic [NUM_CHARS:0]   carry;
  logic [NUM_CHARS-1:0] bad_load;
  logic                 ovf_event;

  logic overflow_q;
  logic overflow_d;
  logic range_err_q;
  logic range_err_d;

  // Load has priority over a step: the step request is dropped at the source.
  assign carry[0] = next & ~load;

  for (genvar i = 0; i < NUM_CHARS; i++) begin : g_digit
    ascii_digit #(
      .CHAR_W     (CHAR_W),
      .FIRST_CHAR (FIRST_CHAR),
      .LAST_CHAR  (LAST_CHAR)
    ) u_digit (
      .clk       (clk),
      .rst       (rst),
      .carry_in  (carry[i]),
      .dir       (dir),
      .load      (load),
      .load_val  (load_value[i*CHAR_W +: CHAR_W]),
      .value     (values[i*CHAR_W +: CHAR_W]),
      .carry_out (carry[i+1]),
      .bad_load  (bad_load[i])
    );
  end

  assign ovf_event = carry[NUM_CHARS];

  always_comb begin
    range_err_d = |bad_load;
    if (STICKY_OVF) begin
      // A new wrap in the same cycle as a clear keeps the flag set.
      overflow_d = ovf_event | (overflow_q & ~ovf_clr);
    end else begin
      overflow_d = ovf_event;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      range_err_q <= range_err_d;
    end
  end

  assign overflow  = overflow_q;
  assign range_err = range_err_q;

endmodule : ascii_n_ints
`default_nettype wire

// File: tb/tb_ascii_n_ints.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascii_n_ints
//  Description : Self-checking bench for ascii_n_ints. Three instances share
//                one stimulus stream: a = defaults (4 x ' '..'~', pulsed),
//                b = 2 x '0'..'9' sticky, c = 2 x '0'..'9' pulsed. Each is
//                tracked by an integer-index odometer model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ascii_n_ints;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next = 1'b0;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] load_value = 32'h0;

  logic [31:0] a_values;
  logic [15:0] b_values;
  logic [15:0] c_values;
  logic        a_ovf, b_ovf, c_ovf;
  logic        a_rerr, b_rerr, c_rerr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ascii_n_ints dut_a (
    .clk(clk), .rst(rst), .next(next), .dir(dir), .load(load),
    .load_value(load_value), .ovf_clr(ovf_clr),
    .values(a_values), .overflow(a_ovf), .range_err(a_rerr)
  );

  ascii_n_ints #(
    .NUM_CHARS(2), .CHAR_W(8), .FIRST_CHAR(8'h30), .LAST_CHAR(8'h39), .STICKY_OVF(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .next(next), .dir(dir), .load(load),
    .load_value(load_value[15:0]), .ovf_clr(ovf_clr),
    .values(b_values), .overflow(b_ovf), .range_err(b_rerr)
  );

  ascii_n_ints #(
    .NUM_CHARS(2), .CHAR_W(8), .FIRST_CHAR(8'h30), .LAST_CHAR(8'h39), .STICKY_OVF(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .next(next), .dir(dir), .load(load),
    .load_value(load_value[15:0]), .ovf_clr(ovf_clr),
    .values(c_values), .overflow(c_ovf), .range_err(c_rerr)
  );

  // ---------------- behavioural model -------------------------------------
  // The odometer state is a single integer in [0, radix^n); stepping is +/-1
  // modulo radix^n, and a wrap of that integer is the overflow event.
  int     m_first [3] = '{32'h20, 32'h30, 32'h30};
  int     m_last  [3] = '{32'h7E, 32'h39, 32'h39};
  int     m_n     [3] = '{4, 2, 2};
  bit     m_sticky[3] = '{1'b0, 1'b1, 1'b0};
  longint m_idx   [3];
  bit     m_ovf   [3];
  bit     m_rerr  [3];
  bit     m_valid = 1'b0;

  always @(posedge clk) begin : p_model
    longint radix, total, pw, acc;
    int     code;
    bit     ev, bad;
    for (int k = 0; k < 3; k++) begin
      radix = m_last[k] - m_first[k] + 1;
      total = 1;
      for (int i = 0; i < m_n[k]; i++) total = total * radix;
      if (rst) begin
        m_idx[k] = 0; m_ovf[k] = 1'b0; m_rerr[k] = 1'b0;
      end else if (load) begin
        acc = 0; pw = 1; bad = 1'b0;
        for (int i = 0; i < m_n[k]; i++) begin
          code = int'(load_value[i*8 +: 8]);
          if (code < m_first[k] || code > m_last[k]) bad = 1'b1;
          else acc = acc + longint'(code - m_first[k]) * pw;
          pw = pw * radix;
        end
        m_idx[k]  = acc;
        m_rerr[k] = bad;
        m_ovf[k]  = m_sticky[k] ? (m_ovf[k] & !ovf_clr) : 1'b0;
      end else if (next) begin
        ev = 1'b0;
        if (!dir) begin
          if (m_idx[k] == total - 1) begin m_idx[k] = 0; ev = 1'b1; end
          else m_idx[k] = m_idx[k] + 1;
        end else begin
          if (m_idx[k] == 0) begin m_idx[k] = total - 1; ev = 1'b1; end
          else m_idx[k] = m_idx[k] - 1;
        end
        m_ovf[k]  = m_sticky[k] ? (ev | (m_ovf[k] & !ovf_clr)) : ev;
        m_rerr[k] = 1'b0;
      end else begin
        m_rerr[k] = 1'b0;
        m_ovf[k]  = m_sticky[k] ? (m_ovf[k] & !ovf_clr) : 1'b0;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  function automatic logic [31:0] m_pack(input int k);
    logic [31:0] out;
    longint radix, rem;
    out   = 32'h0;
    radix = m_last[k] - m_first[k] + 1;
    rem   = m_idx[k];
    for (int i = 0; i < m_n[k]; i++) begin
      out[i*8 +: 8] = 8'(m_first[k] + int'(rem % radix));
      rem = rem / radix;
    end
    return out;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare -------------------------------------
  logic [31:0] act_v [3];
  logic        act_o [3];
  logic        act_r [3];
  assign act_v[0] = a_values;
  assign act_v[1] = {16'h0, b_values};
  assign act_v[2] = {16'h0, c_values};
  assign act_o[0] = a_ovf;
  assign act_o[1] = b_ovf;
  assign act_o[2] = c_ovf;
  assign act_r[0] = a_rerr;
  assign act_r[1] = b_rerr;
  assign act_r[2] = c_rerr;

  string nm[3] = '{"a", "b", "c"};

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk({"model_values_", nm[k]}, act_v[k], m_pack(k));
        chk({"model_overflow_", nm[k]}, 32'(act_o[k]), 32'(m_ovf[k]));
        chk({"model_range_err_", nm[k]}, 32'(act_r[k]), 32'(m_rerr[k]));
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 6))
      0:       return 8'h39;
      1:       return 8'h30;
      2:       return 8'h7E;
      3:       return 8'h20;
      4:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(8'h30, 8'h39));
    endcase
  endfunction

  initial begin
    int r;
    // Reset for two cycles.
    rst = 1'b1;
    cyc(); cyc();
    chk("reset_values_a", a_values, 32'h20202020);
    chk("reset_overflow_a", 32'(a_ovf), 32'd0);
    chk("reset_range_err_a", 32'(a_rerr), 32'd0);
    chk("reset_values_b", {16'h0, b_values}, 32'h3030);
    rst = 1'b0;

    // Wrap up from "99".
    load = 1'b1; load_value = 32'h00003939;
    cyc();
    chk("load_3939_c", {16'h0, c_values}, 32'h3939);
    load = 1'b0; next = 1'b1; dir = 1'b0;
    cyc();
    chk("wrap_up_values_c", {16'h0, c_values}, 32'h3030);
    chk("wrap_up_ovf_c", 32'(c_ovf), 32'd1);
    next = 1'b0;
    cyc();
    chk("wrap_up_ovf_pulse_end_c", 32'(c_ovf), 32'd0);
    chk("wrap_up_ovf_sticky_b", 32'(b_ovf), 32'd1);
    ovf_clr = 1'b1;
    cyc();
    chk("ovf_clr_b", 32'(b_ovf), 32'd0);
    ovf_clr = 1'b0;

    // Carry then borrow.
    load = 1'b1; load_value = 32'h00003039;
    cyc();
    load = 1'b0; next = 1'b1; dir = 1'b0;
    cyc();
    chk("carry_up_c", {16'h0, c_values}, 32'h3130);
    dir = 1'b1;
    cyc();
    chk("borrow_down_c", {16'h0, c_values}, 32'h3039);
    chk("borrow_no_ovf_c", 32'(c_ovf), 32'd0);
    next = 1'b0; dir = 1'b0;

    // Underflow on the sticky instance.
    load = 1'b1; load_value = 32'h00003030;
    cyc();
    load = 1'b0; next = 1'b1; dir = 1'b1;
    cyc();
    chk("underflow_values_b", {16'h0, b_values}, 32'h3939);
    chk("underflow_ovf_b", 32'(b_ovf), 32'd1);
    next = 1'b0; dir = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("sticky_hold_b", 32'(b_ovf), 32'd1);
    end
    ovf_clr = 1'b1;
    cyc();
    chk("sticky_clear_b", 32'(b_ovf), 32'd0);
    ovf_clr = 1'b0;

    // Load with out-of-range channel, colliding with next.
    load = 1'b1; next = 1'b1; load_value = 32'h00004135;
    cyc();
    chk("range_load_values_c", {16'h0, c_values}, 32'h3035);
    chk("range_err_pulse_c", 32'(c_rerr), 32'd1);
    load = 1'b0; next = 1'b0;
    cyc();
    chk("range_err_clear_c", 32'(c_rerr), 32'd0);
    chk("range_hold_values_c", {16'h0, c_values}, 32'h3035);

    // Reset in the middle of a held-next run.
    next = 1'b1; dir = 1'b0;
    cyc();
    chk("run_step1_c", {16'h0, c_values}, 32'h3036);
    cyc();
    chk("run_step2_c", {16'h0, c_values}, 32'h3037);
    rst = 1'b1;
    cyc();
    chk("run_reset_c", {16'h0, c_values}, 32'h3030);
    chk("run_reset_a", a_values, 32'h20202020);
    rst = 1'b0;
    cyc();
    chk("run_resume1_c", {16'h0, c_values}, 32'h3031);
    cyc();
    chk("run_resume2_c", {16'h0, c_values}, 32'h3032);
    next = 1'b0;

    // Randomised phase, checked against the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      r       = $urandom_range(0, 99);
      rst     = (r < 2);
      load    = (r >= 2 && r < 12);
      next    = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      ovf_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       load_value = 32'h7E7E7E7E;
          1:       load_value = 32'h20202020;
          2:       load_value = 32'h39393939;
          default: load_value = 32'h30303030;
        endcase
      end else begin
        for (int i = 0; i < 4; i++) load_value[i*8 +: 8] = pick_byte();
      end
      cyc();
    end
    rst = 1'b0; load = 1'b0; next = 1'b0; ovf_clr = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ascii_n_ints
`default_nettype wire
